// File: rtl/s2p_frame_ctrl.sv
// Frame alignment and shift-register control for the 4-lane serial-to-parallel converter.
// Shadows lane 0, hunts for the sync byte, confirms it, and issues aligned word strobes once locked.
module s2p_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hBC,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned LOSS_CNT  = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [1:0] CFG_MODO,
  input  logic       CFG_DIR,
  input  logic       S_IN0,
  output logic       OUT_ENB,
  output logic [1:0] OUT_MODO,
  output logic       OUT_DIR,
  output logic       WORD_STB,
  output logic [2:0] BIT_CNT,
  output logic       LOCKED,
  output logic       SYNC_ERR
);

  localparam int unsigned WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned GD_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(LOSS_CNT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_LEN - 1);
  localparam logic [GD_W-1:0] GD_MAX  = GD_W'(LOCK_CNT);
  localparam logic [MS_W-1:0] MS_MAX  = MS_W'(LOSS_CNT);

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_CONFIRM, ST_LOCK} state_t;

  state_t          state_q, state_d;
  logic [7:0]      shadow_q, shadow_d;
  logic [2:0]      bit_q, bit_d;
  logic [WC_W-1:0] word_q, word_d;
  logic [GD_W-1:0] good_q, good_d;
  logic [MS_W-1:0] miss_q, miss_d;
  logic [1:0]      modo_q, modo_d;
  logic            dir_q, dir_d;

  logic            match, boundary, sync_pos, sync_err;
  logic [GD_W-1:0] good_inc;
  logic [MS_W-1:0] miss_inc;

  assign match    = (shadow_q == SYNC_BYTE);
  assign boundary = (bit_q == 3'd0);
  assign sync_pos = boundary && (word_q == '0);
  assign good_inc = good_q + 1'b1;
  assign miss_inc = miss_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      modo_q   <= '0;
      dir_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      modo_q   <= modo_d;
      dir_q    <= dir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    word_d   = word_q;
    good_d   = good_q;
    miss_d   = miss_q;
    modo_d   = modo_q;
    dir_d    = dir_q;
    sync_err = 1'b0;

    // Shadow mirrors the lane 0 register, so it must shift the same way.
    if (state_q != ST_IDLE) begin
      shadow_d = dir_q ? {S_IN0, shadow_q[7:1]} : {shadow_q[6:0], S_IN0};
      bit_d    = bit_q + 3'd1;
    end

    if ((state_q == ST_CONFIRM || state_q == ST_LOCK) && boundary) begin
      word_d = (word_q == WC_LAST) ? '0 : word_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          modo_d  = CFG_MODO;
          dir_d   = CFG_DIR;
          state_d = ST_HUNT;
        end
      end
      ST_HUNT: begin
        if (match) begin
          bit_d   = 3'd1;
          word_d  = WC_W'(1);
          good_d  = GD_W'(1);
          state_d = ST_CONFIRM;
        end
      end
      ST_CONFIRM: begin
        // A rejected candidate keeps its bit phase; HUNT simply keeps searching.
        if (sync_pos) begin
          if (match) begin
            good_d = good_inc;
            if (good_inc >= GD_MAX) begin
              good_d  = GD_MAX;
              miss_d  = '0;
              state_d = ST_LOCK;
            end
          end else begin
            state_d = ST_HUNT;
          end
        end
      end
      ST_LOCK: begin
        if (sync_pos) begin
          if (match) begin
            miss_d = '0;
          end else begin
            sync_err = 1'b1;
            miss_d   = miss_inc;
            if (miss_inc >= MS_MAX) begin
              miss_d  = MS_MAX;
              state_d = ST_HUNT;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!START) begin
      state_d  = ST_IDLE;
      shadow_d = '0;
      bit_d    = '0;
      word_d   = '0;
      good_d   = '0;
      miss_d   = '0;
    end
  end

  assign OUT_ENB  = (state_q != ST_IDLE);
  assign OUT_MODO = (state_q != ST_IDLE) ? modo_q : 2'b00;
  assign OUT_DIR  = (state_q != ST_IDLE) ? dir_q : 1'b0;
  assign LOCKED   = (state_q == ST_LOCK);
  assign WORD_STB = (state_q == ST_LOCK) && boundary;
  assign BIT_CNT  = bit_q;
  assign SYNC_ERR = sync_err;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl: lock, false sync, loss of lock, DIR=1, abort and reset.
module tb_s2p_frame_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [1:0] CFG_MODO;
  logic       CFG_DIR;
  logic       S_IN0;
  logic       OUT_ENB;
  logic [1:0] OUT_MODO;
  logic       OUT_DIR;
  logic       WORD_STB;
  logic [2:0] BIT_CNT;
  logic       LOCKED;
  logic       SYNC_ERR;

  s2p_frame_ctrl #(
    .SYNC_BYTE(8'hBC),
    .FRAME_LEN(4),
    .LOCK_CNT (3),
    .LOSS_CNT (2)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .START   (START),
    .CFG_MODO(CFG_MODO),
    .CFG_DIR (CFG_DIR),
    .S_IN0   (S_IN0),
    .OUT_ENB (OUT_ENB),
    .OUT_MODO(OUT_MODO),
    .OUT_DIR (OUT_DIR),
    .WORD_STB(WORD_STB),
    .BIT_CNT (BIT_CNT),
    .LOCKED  (LOCKED),
    .SYNC_ERR(SYNC_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc;
  int          pre_n;
  logic [2:0]  pre_bits;
  int          sb;
  logic        dir_s;
  int          false_f;
  logic [63:0] corrupt;
  logic [7:0]  fb [4];

  // Bit n of the lane 0 stream: prefix bits, then frames of fb[] with optional
  // corrupted sync words and one injected false sync byte in payload slot 2.
  function automatic logic stream_bit(input int n);
    int         m, bi, f, idx, pos;
    logic [7:0] b;
    if (n < pre_n) return pre_bits[n];
    m   = n - pre_n;
    bi  = m / 8 + sb;
    f   = bi / 4;
    idx = bi % 4;
    pos = m % 8;
    b   = fb[idx];
    if (idx == 0 && f < 64 && corrupt[f]) b = 8'h00;
    if (idx == 2 && f == false_f) b = 8'hBC;
    return dir_s ? b[pos] : b[7 - pos];
  endfunction

  task automatic edge_();
    @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    S_IN0 = stream_bit(cyc + 1);
    edge_();
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic restart(input logic [1:0] modo, input logic dir);
    START = 1'b0;
    edge_();
    chk("stop_enb", 8'(OUT_ENB), 8'd0);
    CFG_MODO = modo;
    CFG_DIR  = dir;
    START    = 1'b1;
    edge_();
    chk("start_enb", 8'(OUT_ENB), 8'd1);
    chk("start_modo", 8'(OUT_MODO), 8'(modo));
    chk("start_dir", 8'(OUT_DIR), 8'(dir));
    cyc = -1;
  endtask

  initial begin
    RESET    = 1'b1;
    START    = 1'b1;
    CFG_MODO = 2'b10;
    CFG_DIR  = 1'b0;
    S_IN0    = 1'b0;
    pre_n    = 3;
    pre_bits = 3'b101;
    sb       = 0;
    dir_s    = 1'b0;
    false_f  = -1;
    corrupt  = '0;
    fb[0] = 8'hBC; fb[1] = 8'h12; fb[2] = 8'h34; fb[3] = 8'h56;
    cyc = -1;

    // Reset held two cycles with START high
    edge_();
    edge_();
    chk("rst_enb", 8'(OUT_ENB), 8'd0);
    chk("rst_modo", 8'(OUT_MODO), 8'd0);
    chk("rst_dir", 8'(OUT_DIR), 8'd0);
    chk("rst_stb", 8'(WORD_STB), 8'd0);
    chk("rst_bitcnt", 8'(BIT_CNT), 8'd0);
    chk("rst_locked", 8'(LOCKED), 8'd0);
    chk("rst_syncerr", 8'(SYNC_ERR), 8'd0);
    RESET = 1'b0;
    edge_();
    chk("rel_enb", 8'(OUT_ENB), 8'd1);
    chk("rel_modo", 8'(OUT_MODO), 8'd2);
    cyc = -1;

    // Clean lock, then loss of lock via corrupted sync words of frames 5, 7, 8
    corrupt[5] = 1'b1;
    corrupt[7] = 1'b1;
    corrupt[8] = 1'b1;
    run_to(10);
    chk("hunt_bitcnt", 8'(BIT_CNT), 8'd3);
    chk("hunt_locked", 8'(LOCKED), 8'd0);
    run_to(11);
    chk("confirm_bitcnt", 8'(BIT_CNT), 8'd1);
    run_to(74);
    chk("pre_lock", 8'(LOCKED), 8'd0);
    run_to(75);
    chk("lock_rise", 8'(LOCKED), 8'd1);
    chk("lock_bitcnt", 8'(BIT_CNT), 8'd1);
    run_to(81);
    chk("stb_low", 8'(WORD_STB), 8'd0);
    run_to(82);
    chk("stb_82", 8'(WORD_STB), 8'd1);
    chk("stb_82_bitcnt", 8'(BIT_CNT), 8'd0);
    run_to(83);
    chk("stb_83", 8'(WORD_STB), 8'd0);
    run_to(90);
    chk("stb_90", 8'(WORD_STB), 8'd1);
    run_to(106);
    chk("sync_ok_err", 8'(SYNC_ERR), 8'd0);
    chk("sync_ok_stb", 8'(WORD_STB), 8'd1);
    run_to(170);
    chk("miss1_err", 8'(SYNC_ERR), 8'd1);
    chk("miss1_stb", 8'(WORD_STB), 8'd1);
    chk("miss1_locked", 8'(LOCKED), 8'd1);
    run_to(171);
    chk("miss1_err_end", 8'(SYNC_ERR), 8'd0);
    chk("miss1_hold", 8'(LOCKED), 8'd1);
    run_to(202);
    chk("recover_err", 8'(SYNC_ERR), 8'd0);
    run_to(234);
    chk("miss2a_err", 8'(SYNC_ERR), 8'd1);
    run_to(235);
    chk("miss2a_locked", 8'(LOCKED), 8'd1);
    run_to(266);
    chk("miss2b_err", 8'(SYNC_ERR), 8'd1);
    chk("miss2b_locked", 8'(LOCKED), 8'd1);
    run_to(267);
    chk("loss_locked", 8'(LOCKED), 8'd0);
    chk("loss_enb", 8'(OUT_ENB), 8'd1);

    // False sync byte seen first; CONFIRM must reject it and relock on the true boundary
    corrupt = '0;
    false_f = 0;
    sb      = 2;
    restart(2'b10, 1'b0);
    run_to(11);
    chk("false_confirm", 8'(BIT_CNT), 8'd1);
    run_to(42);
    chk("false_check_err", 8'(SYNC_ERR), 8'd0);
    run_to(75);
    chk("false_no_lock", 8'(LOCKED), 8'd0);
    run_to(122);
    chk("true_pre_lock", 8'(LOCKED), 8'd0);
    run_to(123);
    chk("true_lock", 8'(LOCKED), 8'd1);
    run_to(130);
    chk("true_stb", 8'(WORD_STB), 8'd1);
    chk("true_stb_bitcnt", 8'(BIT_CNT), 8'd0);
    run_to(154);
    chk("true_sync_stb", 8'(WORD_STB), 8'd1);
    chk("true_sync_err", 8'(SYNC_ERR), 8'd0);

    // DIR=1, LSB-first stream; config frozen while running
    false_f = -1;
    sb      = 0;
    dir_s   = 1'b1;
    restart(2'b01, 1'b1);
    run_to(10);
    chk("dir1_hunt_bitcnt", 8'(BIT_CNT), 8'd3);
    run_to(11);
    chk("dir1_confirm", 8'(BIT_CNT), 8'd1);
    run_to(74);
    chk("dir1_pre_lock", 8'(LOCKED), 8'd0);
    run_to(75);
    chk("dir1_lock", 8'(LOCKED), 8'd1);
    CFG_MODO = 2'b11;
    CFG_DIR  = 1'b0;
    run_to(82);
    chk("dir1_stb", 8'(WORD_STB), 8'd1);
    chk("freeze_modo", 8'(OUT_MODO), 8'd1);
    chk("freeze_dir", 8'(OUT_DIR), 8'd1);
    run_to(106);
    chk("dir1_sync_err", 8'(SYNC_ERR), 8'd0);
    chk("dir1_sync_locked", 8'(LOCKED), 8'd1);

    // START dropped during LOCK
    START = 1'b0;
    edge_();
    chk("abort_enb", 8'(OUT_ENB), 8'd0);
    chk("abort_modo", 8'(OUT_MODO), 8'd0);
    chk("abort_dir", 8'(OUT_DIR), 8'd0);
    chk("abort_locked", 8'(LOCKED), 8'd0);
    chk("abort_stb", 8'(WORD_STB), 8'd0);
    chk("abort_bitcnt", 8'(BIT_CNT), 8'd0);

    // RESET asserted during CONFIRM
    dir_s = 1'b0;
    restart(2'b10, 1'b0);
    run_to(20);
    chk("cfm_bitcnt", 8'(BIT_CNT), 8'd2);
    RESET = 1'b1;
    edge_();
    chk("midrst_enb", 8'(OUT_ENB), 8'd0);
    chk("midrst_bitcnt", 8'(BIT_CNT), 8'd0);
    chk("midrst_modo", 8'(OUT_MODO), 8'd0);
    chk("midrst_locked", 8'(LOCKED), 8'd0);
    RESET = 1'b0;
    edge_();
    chk("postrst_enb", 8'(OUT_ENB), 8'd1);
    chk("postrst_modo", 8'(OUT_MODO), 8'd2);
    chk("postrst_bitcnt", 8'(BIT_CNT), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
- Control and alignment block for the 4-lane serial-to-parallel converter. Runs on the bit clock (2 MHz domain).
- Shadows lane 0 to find a sync byte and locks to the word boundary.
- Drives the shift-register controls ENB, MODO and DIR.
- Produces a one-cycle word strobe that replaces the free-running divided clock as the capture enable for the parallel output flops.

Parameters:
SYNC_BYTE, 8'hBC, marker byte expected on lane 0 at the first word of every frame
FRAME_LEN, 4, words per frame, sync word included; legal range 2..16
LOCK_CNT, 3, consecutive correct sync words needed to declare lock
LOSS_CNT, 2, consecutive missing sync words in lock that force a re-hunt

Ports:
CLK  in  1  bit clock; all logic on the rising edge
RESET  in  1  synchronous, active-high; sampled on the CLK rising edge
START  in  1  level; 1 = run, 0 = stop and return to idle
CFG_MODO  in  2  requested shift mode, latched when leaving IDLE
CFG_DIR  in  1  requested shift direction, latched when leaving IDLE
S_IN0  in  1  lane 0 serial bit, the same bit the lane 0 register shifts this edge
OUT_ENB  out  1  enable to all shift registers and output flops
OUT_MODO  out  2  mode to the shift registers
OUT_DIR  out  1  direction to the shift registers
WORD_STB  out  1  one-cycle capture strobe at an aligned word boundary
BIT_CNT  out  3  bits received in the current word, modulo 8
LOCKED  out  1  high in LOCK state
SYNC_ERR  out  1  one-cycle pulse on a missed sync word while locked

Behaviour:
- Reset: state IDLE; shadow, BIT_CNT, word counter, good/miss counters = 0. All outputs = 0.
- RESET has priority over every other input, including mid-frame.
- Shadow register, 8 bits, updated every cycle when the state is not IDLE:
  - OUT_DIR = 0: shadow <= {shadow[6:0], S_IN0}.
  - OUT_DIR = 1: shadow <= {S_IN0, shadow[7:1]}.
  - The shadow therefore equals the lane 0 register contents.
- "match" = (registered shadow == SYNC_BYTE).
- States: IDLE, HUNT, CONFIRM, LOCK. START = 0 in any state returns to IDLE on the next edge and clears all counters.
- IDLE:
  - OUT_ENB = 0, OUT_MODO = 00, OUT_DIR = 0.
  - START = 1 latches CFG_MODO and CFG_DIR and moves to HUNT.
  - CFG changes while not in IDLE are ignored.
- HUNT, CONFIRM and LOCK: OUT_ENB = 1; OUT_MODO and OUT_DIR = latched config.
- HUNT:
  - BIT_CNT free-runs.
  - On the first cycle with match: BIT_CNT <= 1, word counter <= 1, good <= 1, go to CONFIRM.
- Word boundary = cycle with BIT_CNT == 0 in CONFIRM or LOCK.
  - BIT_CNT increments every cycle and wraps 7 -> 0.
  - The word counter increments at each boundary, modulo FRAME_LEN.
- Sync position = a boundary with word counter == 0, i.e. FRAME_LEN*8 cycles after the previous sync.
- CONFIRM:
  - At a sync position with match: good++. When good reaches LOCK_CNT, go to LOCK.
  - At a sync position without match: go to HUNT; good and BIT_CNT are not reset by this transition.
  - No checks at other boundaries.
- LOCK:
  - LOCKED = 1.
  - WORD_STB = 1 on every boundary; this is Moore decode of state and BIT_CNT, not registered.
  - At a sync position with match: miss <= 0.
  - At a sync position without match: SYNC_ERR pulses that cycle and miss++. When miss reaches LOSS_CNT, go to HUNT with LOCKED = 0 next cycle.
  - The sync-position word still gets WORD_STB.
- SYNC_BYTE appearing in payload is ignored in CONFIRM and LOCK. In HUNT the first match is taken; a false alignment is rejected by CONFIRM.
- Widths: word counter = ceil(log2(FRAME_LEN)) bits; good and miss counters saturate at their thresholds.

Test Plan:
- Reset and start: RESET high for 2 cycles with START = 1 -> all outputs 0. After release, OUT_ENB = 1 and OUT_MODO = CFG_MODO on the next cycle.
- Clean lock: DIR = 0, stream 8'hBC + 3 payload bytes, repeated. Bits arrive at 1 bit/cycle, 3 random bits first (so SYNC_BYTE completes at cycle 11) -> CONFIRM at cycle 11. LOCKED rises after the 3rd sync (cycle 11 + 2*32 = 75). WORD_STB then every 8 cycles; BIT_CNT == 0 on each strobe.
- False sync: payload contains 8'hBC at a non-frame position, real sync offset by 3 bits -> CONFIRM rejects the false sync at the next sync position, returns to HUNT, then locks to the true boundary.
- Loss of lock: while locked, corrupt 1 sync word -> SYNC_ERR pulse, LOCKED stays 1. Corrupt 2 consecutive sync words -> LOCKED = 0 one cycle after the second SYNC_ERR, state HUNT.
- DIR = 1 and config freeze: CFG_DIR = 1, stream LSB-first -> locks identically. Toggling CFG_MODO during LOCK -> OUT_MODO unchanged.
- Mid-operation abort: START dropped during LOCK -> IDLE next cycle, all outputs 0. RESET asserted during CONFIRM -> counters and outputs 0 on the next edge.
